// File: rtl/dg0045_io_pkg.sv
// Shared constants for the DG0045 key/display front end: scan geometry,
// default timing parameters and the hex seven-segment table.
package dg0045_io_pkg;

    localparam int SCAN_SLOTS = 4;
    localparam int DIV_W_DEF  = 10;
    localparam int DEB_N_DEF  = 3;

    // Segment order {g,f,e,d,c,b,a}, active-high; entry 15 first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
        7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
        7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
        7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
    };

endpackage

// File: rtl/dg0045_hex7seg.sv
// Combinational hex digit to seven-segment decoder.
module dg0045_hex7seg
    import dg0045_io_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/dg0045_key_display.sv
// Multiplexed 4-digit display and 4x4 key-matrix scanner for the DG0045 core:
// captures L on ND rising edges, scans digits/rows and debounces keys to KIN.
module dg0045_key_display
    import dg0045_io_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int DEB_N = DEB_N_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] nl_in,
    input  logic       nd_in,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] dig_out,
    output logic [6:0] seg_out,
    output logic [3:0] kin_out
);

    localparam logic [1:0] DEB_LAST = 2'(DEB_N - 1);

    logic [3:0]       nl_meta, nl_sync;
    logic             nd_meta, nd_sync, nd_prev;
    logic [3:0]       col_meta, col_sync;
    logic [2:0]       arm_cnt;
    logic             armed, nd_rise;
    logic [3:0]       digit [SCAN_SLOTS];
    logic [1:0]       wr_ptr;
    logic [DIV_W-1:0] pres;
    logic [1:0]       scan;
    logic             slot_end, frame_end;
    logic [15:0]      raw, raw_frame, deb;
    logic [1:0]       deb_cnt [16];
    logic [3:0]       sel_n;
    logic [3:0]       seg_hex;
    logic [6:0]       seg_next;
    logic [3:0]       kin_next;

    // Edges are ignored until the synchronizer has flushed its reset contents.
    assign armed     = arm_cnt[2];
    assign nd_rise   = armed & nd_sync & ~nd_prev;
    assign slot_end  = &pres;
    assign frame_end = slot_end && (scan == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nl_meta  <= '0;
            nl_sync  <= '0;
            nd_meta  <= 1'b0;
            nd_sync  <= 1'b0;
            col_meta <= '0;
            col_sync <= '0;
            nd_prev  <= 1'b1;
            arm_cnt  <= '0;
        end else begin
            nl_meta  <= nl_in;
            nl_sync  <= nl_meta;
            nd_meta  <= nd_in;
            nd_sync  <= nd_meta;
            col_meta <= col_in;
            col_sync <= col_meta;
            nd_prev  <= armed ? nd_sync : 1'b1;
            if (!armed)
                arm_cnt <= arm_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SCAN_SLOTS; i++)
                digit[i] <= '0;
            wr_ptr <= '0;
        end else if (nd_rise) begin
            digit[wr_ptr] <= ~nl_sync;
            wr_ptr        <= wr_ptr + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres <= '0;
            scan <= '0;
            raw  <= '0;
        end else begin
            pres <= pres + DIV_W'(1);
            if (slot_end) begin
                scan                  <= scan + 2'd1;
                raw[{scan, 2'b00} +: 4] <= ~col_sync;
            end
        end
    end

    // Row 3 is sampled on the same clk the frame is evaluated.
    always_comb begin
        raw_frame        = raw;
        raw_frame[15:12] = ~col_sync;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            for (int k = 0; k < 16; k++)
                deb_cnt[k] <= '0;
        end else if (frame_end) begin
            for (int k = 0; k < 16; k++) begin
                if (raw_frame[k] == deb[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_LAST) begin
                    deb[k]     <= ~deb[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 2'd1;
                end
            end
        end
    end

    // Key 0 never reaches the core; lowest pressed index wins.
    always_comb begin
        kin_next = '0;
        for (int k = 15; k >= 1; k--)
            if (deb[k])
                kin_next = 4'(k);
    end

    assign seg_hex = digit[scan];

    dg0045_hex7seg u_hex7seg (
        .hex (seg_hex),
        .seg (seg_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_n   <= 4'b1111;
            seg_out <= '0;
            kin_out <= '0;
        end else begin
            sel_n   <= ~(4'b0001 << scan);
            seg_out <= seg_next;
            kin_out <= kin_next;
        end
    end

    assign dig_out = sel_n;
    assign row_out = sel_n;

endmodule

// File: tb/tb_dg0045_key_display.sv
// Directed bench for dg0045_key_display with DIV_W=2 (4-clk slots) and DEB_N=3.
module tb_dg0045_key_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] nl_in = 4'hF;
    logic       nd_in = 1'b1;
    logic [3:0] col_in;
    logic [3:0] row_out, dig_out, kin_out;
    logic [6:0] seg_out;
    logic       press0 = 1'b0, press6 = 1'b0, press9 = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    dg0045_key_display #(.DIV_W(2), .DEB_N(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .nl_in   (nl_in),
        .nd_in   (nd_in),
        .col_in  (col_in),
        .row_out (row_out),
        .dig_out (dig_out),
        .seg_out (seg_out),
        .kin_out (kin_out)
    );

    always #5 clk = ~clk;

    // Key matrix model: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_in = 4'b1111;
        if (press0 && row_out == 4'b1110) col_in[0] = 1'b0;
        if (press6 && row_out == 4'b1101) col_in[2] = 1'b0;
        if (press9 && row_out == 4'b1011) col_in[1] = 1'b0;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_dig(input logic [3:0] pat, input string tag);
        logic [3:0] prev;
        bit         found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            prev = dig_out;
            @(negedge clk);
            if (dig_out == pat && prev != pat) found = 1'b1;
        end
        check({tag, "_wait"}, {7'd0, found}, 8'd1);
    endtask

    task automatic nd_pulse(input logic [3:0] v);
        @(negedge clk);
        nl_in = ~v;
        nd_in = 1'b0;
        step(2);
        nd_in = 1'b1;
        step(5);
    endtask

    initial begin
        logic [3:0] e;

        // Reset values
        step(3);
        check("rst_dig", {4'd0, dig_out}, 8'h0F);
        check("rst_row", {4'd0, row_out}, 8'h0F);
        check("rst_seg", {1'b0, seg_out}, 8'h00);
        check("rst_kin", {4'd0, kin_out}, 8'h00);

        // Idle scan after release
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            e = ~(4'b0001 << ((n - 1) / 4));
            check("idle_dig", {4'd0, dig_out}, {4'd0, e});
        end
        check("idle_row", {4'd0, row_out}, {4'd0, e});
        step(4);
        check("idle_seg", {1'b0, seg_out}, 8'h3F);
        check("idle_kin", {4'd0, kin_out}, 8'h00);

        // Digit capture
        nd_pulse(4'h5);
        nd_pulse(4'hA);
        nd_pulse(4'h0);
        nd_pulse(4'hF);
        wait_dig(4'b1110, "d0"); check("seg_d0_5", {1'b0, seg_out}, 8'h6D);
        wait_dig(4'b1101, "d1"); check("seg_d1_A", {1'b0, seg_out}, 8'h77);
        wait_dig(4'b1011, "d2"); check("seg_d2_0", {1'b0, seg_out}, 8'h3F);
        wait_dig(4'b0111, "d3"); check("seg_d3_F", {1'b0, seg_out}, 8'h71);
        nd_pulse(4'h8);
        wait_dig(4'b1110, "d0w"); check("seg_wrap_8", {1'b0, seg_out}, 8'h7F);
        nd_pulse(4'h1);
        nd_pulse(4'h2);
        wait_dig(4'b1101, "d1b"); check("seg_d1_1", {1'b0, seg_out}, 8'h06);
        wait_dig(4'b1011, "d2b"); check("seg_d2_2", {1'b0, seg_out}, 8'h5B);

        // ND rise lands on the clk the scan enters slot 3 (wr_ptr = 3)
        @(negedge clk);
        nl_in = ~4'h6;
        nd_in = 1'b0;
        step(2);
        wait_dig(4'b1011, "s3a");
        nd_in = 1'b1;
        check("seg_s2_old", {1'b0, seg_out}, 8'h5B);
        wait_dig(4'b0111, "s3b"); check("seg_s3_new", {1'b0, seg_out}, 8'h7D);
        step(3);
        nd_pulse(4'h9);
        wait_dig(4'b1110, "ptr0"); check("seg_ptr0_9", {1'b0, seg_out}, 8'h6F);
        wait_dig(4'b0111, "s3c");  check("seg_s3_keep", {1'b0, seg_out}, 8'h7D);

        // Key 6 press and release
        wait_dig(4'b1110, "k6p");
        press6 = 1'b1;
        step(44); check("k6_before", {4'd0, kin_out}, 8'h00);
        step(6);  check("k6_on", {4'd0, kin_out}, 8'h06);
        wait_dig(4'b1110, "k6r");
        press6 = 1'b0;
        step(44); check("k6_held", {4'd0, kin_out}, 8'h06);
        step(6);  check("k6_off", {4'd0, kin_out}, 8'h00);

        // Two-frame glitch
        wait_dig(4'b1110, "glt");
        press6 = 1'b1;
        step(32);
        press6 = 1'b0;
        step(28); check("k6_glitch", {4'd0, kin_out}, 8'h00);

        // Keys 6 and 9 together, then key 0 alone
        press6 = 1'b1;
        press9 = 1'b1;
        step(60); check("k6_k9", {4'd0, kin_out}, 8'h06);
        press6 = 1'b0;
        press9 = 1'b0;
        step(70); check("k69_off", {4'd0, kin_out}, 8'h00);
        press0 = 1'b1;
        step(60); check("k0_ignored", {4'd0, kin_out}, 8'h00);
        press0 = 1'b0;
        step(70);

        // Asynchronous reset mid-slot 2 with key 6 debounced
        press6 = 1'b1;
        step(60); check("k6_pre_rst", {4'd0, kin_out}, 8'h06);
        wait_dig(4'b1011, "rs2");
        step(1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dig", {4'd0, dig_out}, 8'h0F);
        check("arst_row", {4'd0, row_out}, 8'h0F);
        check("arst_seg", {1'b0, seg_out}, 8'h00);
        check("arst_kin", {4'd0, kin_out}, 8'h00);
        press6 = 1'b0;
        nl_in  = ~4'h7;
        nd_in  = 1'b0;
        step(3);
        rst_n = 1'b1;
        @(negedge clk);
        nd_in = 1'b1;
        check("rel_dig1", {4'd0, dig_out}, 8'h0E);
        step(3); check("rel_dig4", {4'd0, dig_out}, 8'h0E);
        step(1); check("rel_dig5", {4'd0, dig_out}, 8'h0D);
        step(20);
        wait_dig(4'b1110, "rel0"); check("rel_no_write", {1'b0, seg_out}, 8'h3F);
        check("rel_kin", {4'd0, kin_out}, 8'h00);
        nd_pulse(4'h4);
        wait_dig(4'b1110, "rel1"); check("rel_write_d0", {1'b0, seg_out}, 8'h66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
